// File: rtl/mux_pkg.sv
// mux_pkg: shared mode and output-stage state enums for mux_arb_n.
package mux_pkg;
    typedef enum logic {MODE_FIXED, MODE_RR} mode_e;
    typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational wrap-around priority search starting at ptr.
module rr_arbiter #(
    parameter int NumInputs = 4,
    parameter int SelWidth  = $clog2(NumInputs)
) (
    input  logic [NumInputs-1:0] req,
    input  logic [SelWidth-1:0]  ptr,
    output logic [SelWidth-1:0]  grant,
    output logic                 grant_valid
);
    logic [SelWidth-1:0] idx;

    // Walk from farthest to nearest so the channel closest to ptr wins; ptr
    // values >= NumInputs are folded back into range by the modulo.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            idx = SelWidth'((int'(ptr) + k) % NumInputs);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready mux with a one-word registered output stage,
// channel chosen by an external selector or by round-robin arbitration.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int    BusWidth  = 32,
    parameter int    NumInputs = 4,
    parameter int    SelWidth  = $clog2(NumInputs),
    parameter mode_e Mode      = MODE_FIXED
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NumInputs-1:0][BusWidth-1:0]  in_data,
    input  logic [NumInputs-1:0]                in_valid,
    output logic [NumInputs-1:0]                in_ready,
    input  logic [SelWidth-1:0]                 selector,
    output logic [BusWidth-1:0]                 out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SelWidth-1:0]                 out_sel
);
    state_e              state, state_next;
    logic [SelWidth-1:0] ptr, ptr_next, arb_ptr, grant;
    logic                grant_valid, granted, load_en, xfer;

    assign arb_ptr = (Mode == MODE_RR) ? ptr : selector;

    rr_arbiter #(
        .NumInputs(NumInputs),
        .SelWidth (SelWidth)
    ) u_arb (
        .req        (in_valid),
        .ptr        (arb_ptr),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    // Fixed mode: the search starts at selector, so only a hit on selector itself counts.
    assign granted   = (Mode == MODE_RR) ? grant_valid
                     : grant_valid && grant == selector && int'(selector) < NumInputs;
    assign load_en   = (state == EMPTY) || out_ready;
    assign xfer      = reset_n && load_en && granted;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end

    always_comb begin
        in_ready   = '0;
        state_next = xfer ? FULL : (state == FULL && out_ready) ? EMPTY : state;
        ptr_next   = !xfer ? ptr : (grant == SelWidth'(NumInputs - 1)) ? '0 : grant + 1'b1;
        for (int i = 0; i < NumInputs; i++)
            in_ready[i] = xfer && grant == SelWidth'(i);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (xfer) begin
            out_data <= in_data[grant];
            out_sel  <= grant;
        end
endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter BusWidth, default 32, data width of every channel and of the output.
REQ-002 SHALL have parameter NumInputs, default 4, channel count; legal range 2..16.
REQ-003 SHALL have parameter SelWidth, default $clog2(NumInputs), selector/grant width; never overridden below $clog2(NumInputs).
REQ-004 SHALL have parameter Mode, default MODE_FIXED; MODE_FIXED uses the external selector, MODE_RR uses round-robin arbitration.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_data  input  NumInputs x BusWidth  per-channel data.
REQ-008 SHALL have port in_valid  input  NumInputs  per-channel data-present flag.
REQ-009 SHALL have port in_ready  output  NumInputs  per-channel accept; a transfer occurs on channel i when in_valid[i] && in_ready[i].
REQ-010 SHALL have port selector  input  SelWidth  channel choice, MODE_FIXED only; ignored in MODE_RR.
REQ-011 SHALL have port out_data  output  BusWidth  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_sel  output  SelWidth  index of the channel that supplied out_data.

Function
REQ-015 SHALL implement a two-state output stage, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define load_en = (state==EMPTY) || out_ready; no input is accepted when load_en=0.
REQ-017 SHALL, in MODE_FIXED, grant channel selector when selector < NumInputs and in_valid[selector]=1; otherwise no grant.
REQ-018 SHALL, in MODE_RR, grant the first channel with in_valid=1 searching from pointer ptr upward, wrapping from NumInputs-1 to 0.
REQ-019 SHALL advance ptr to (grant+1) mod NumInputs only on a cycle with a completed input transfer; ptr is unchanged otherwise.
REQ-020 SHALL drive in_ready[i]=1 only for i==grant and only when load_en=1; at most one in_ready bit is high per cycle.
REQ-021 SHALL, on an input transfer, register in_data[grant] into out_data, grant into out_sel, and enter FULL on the next edge: latency 1 cycle.
REQ-022 SHALL, in FULL with out_ready=0, hold out_data, out_sel and out_valid stable.
REQ-023 SHALL, in FULL with out_ready=1 and a new grant in the same cycle, replace the word and stay FULL: sustained throughput of 1 word/cycle.
REQ-024 SHALL, in FULL with out_ready=1 and no grant, return to EMPTY; out_data keeps its last value.
REQ-025 SHALL leave out_data and out_sel unchanged in every cycle without an input transfer.
REQ-026 SHALL treat selector >= NumInputs (non-power-of-2 NumInputs) as no request; no X propagation and no out-of-range indexing.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=0 and in_ready=0.
REQ-028 SHALL discard any word held at reset assertion, including one in the middle of a stalled transfer; no transfer completes in the deassertion cycle's preceding edge.

Structure
REQ-029 SHALL take the mode enum (MODE_FIXED, MODE_RR) and the state enum (EMPTY, FULL) from shared package mux_pkg.
REQ-030 SHALL place the combinational wrap-around priority search in sub-module rr_arbiter (inputs req, ptr; output grant, grant_valid), instantiated in both modes with ptr tied to selector in MODE_FIXED and a one-hot gate on that channel only.

Verification
REQ-031 SHALL cover: MODE_FIXED, NumInputs=4, selector=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2.
REQ-032 SHALL cover: MODE_RR, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
REQ-033 SHALL cover: MODE_RR, ptr=3, in_valid=4'b0010 -> grant=1 (wrap), ptr becomes 2.
REQ-034 SHALL cover: FULL with out_data=32'h1, out_ready=0 for 5 cycles while in_valid=4'b1111 -> in_ready=0, out_data stays 32'h1, ptr unchanged.
REQ-035 SHALL cover: NumInputs=3, MODE_FIXED, selector=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-036 SHALL cover: reset_n pulsed low mid-cycle in FULL -> out_valid=0, out_data=0, ptr=0 immediately, before the next clk edge.
